// File: rtl/baw_pkg.sv
// Shared button index map and helpers for the game FSM and the button front end.
package baw_pkg;

    localparam int unsigned N_BTN      = 5;
    localparam int unsigned BTN_CENTER = 0;
    localparam int unsigned BTN_TOP    = 1;
    localparam int unsigned BTN_BOTTOM = 2;
    localparam int unsigned BTN_LEFT   = 3;
    localparam int unsigned BTN_RIGHT  = 4;

    typedef logic [N_BTN-1:0] btn_vec_t;

    // Keep only the lowest-index set bit; lower index means higher priority.
    function automatic btn_vec_t first_set(input btn_vec_t v);
        btn_vec_t res;
        logic     found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (v[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    // Mask of every button except index idx.
    function automatic btn_vec_t others_mask(input int unsigned idx);
        btn_vec_t m;
        m      = '1;
        m[idx] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, agreement-reset debounce counter, stable level
// and a combinational flag marking the edge on which the stable level rises.
module btn_debounce
    import baw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any cycle of agreement restarts the count, so glitches never accumulate.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level = stable_q;
    assign rise  = stable_d & ~stable_q;

endmodule

// File: rtl/btn_conditioner.sv
// Five-button front end: per-channel debounce plus a lockout/priority stage that turns
// debounced press edges into at most one single-cycle pulse per clock.
module btn_conditioner
    import baw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_level,
    output logic             any_held
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    btn_vec_t level;
    btn_vec_t rise;
    btn_vec_t cand;
    btn_vec_t pulse_d;
    btn_vec_t pulse_q;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[g]),
            .level (level[g]),
            .rise  (rise[g])
        );
    end

    // A rise only counts if no other button was already held before this edge.
    always_comb begin
        cand = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cand[i] = rise[i] && ((level & others_mask(i)) == '0);
        end
        pulse_d = first_set(cand);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;
    assign btn_level = level;
    assign any_held  = |level;

endmodule
